// File: rtl/sdram_test_pkg.sv
// Shared types and constants for the SDRAM pattern tester: FSM state codes,
// pattern modes and the 16-bit Fibonacci LFSR step.
package sdram_test_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_WR_GAP  = 4'd1,
    ST_WR_REQ  = 4'd2,
    ST_WR_NEXT = 4'd3,
    ST_TURN    = 4'd4,
    ST_RD_REQ  = 4'd5,
    ST_RD_WAIT = 4'd6,
    ST_CMP     = 4'd7,
    ST_RD_NEXT = 4'd8,
    ST_PASS    = 4'd9,
    ST_FAIL    = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    PAT_ADDR  = 2'd0,
    PAT_NADDR = 2'd1,
    PAT_WALK1 = 2'd2,
    PAT_LFSR  = 2'd3
  } mode_t;

  // x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form: feedback from bits 0,2,3,5
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/sdram_pattern_gen.sv
// Expected-word generator shared by the write and compare paths; the LFSR
// advances once per accepted write and once per compare.
module sdram_pattern_gen
  import sdram_test_pkg::*;
#(
  parameter int          DATA_W    = 16,
  parameter int          DEPTH_W   = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               iCLK,
  input  logic               iRST_n,
  input  mode_t              mode,
  input  logic [DEPTH_W-1:0] address,
  input  logic               lfsr_load,
  input  logic               lfsr_step,
  output logic [DATA_W-1:0]  expected
);

  logic [15:0]               lfsr;
  logic [DATA_W+DEPTH_W-1:0] addr_ext;

  assign addr_ext = {{DATA_W{1'b0}}, address};

  always_ff @(posedge iCLK) begin
    if (!iRST_n || lfsr_load) lfsr <= LFSR_SEED;
    else if (lfsr_step)       lfsr <= lfsr_next(lfsr);
  end

  always_comb begin
    expected = '0;
    case (mode)
      PAT_ADDR:  expected = addr_ext[DATA_W-1:0];
      PAT_NADDR: expected = ~addr_ext[DATA_W-1:0];
      PAT_WALK1: for (int i = 0; i < DATA_W; i++)
                   expected[i] = ((int'(address) % DATA_W) == i);
      // wider words replicate the 16-bit register
      PAT_LFSR:  for (int i = 0; i < DATA_W; i++)
                   expected[i] = lfsr[i % 16];
      default:   expected = '0;
    endcase
  end

endmodule

// File: rtl/sdram_pattern_tester.sv
// Push-button SDRAM write/read-back tester: writes a pattern over the window,
// reads each word back with one read outstanding, and reports pass/fail.
module sdram_pattern_tester
  import sdram_test_pkg::*;
#(
  parameter int          ADDR_W     = 25,
  parameter int          DATA_W     = 16,
  parameter int          DEPTH_W    = 16,
  parameter int          GAP_CYCLES = 8,
  parameter int          TIMEOUT_W  = 8,
  parameter int          ERR_W      = 16,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic               iCLK,
  input  logic               iRST_n,
  input  logic               iBUTTON,
  input  logic [1:0]         iMODE,
  input  logic               iSTOP_ON_ERR,
  output logic               oWRITE,
  output logic               oREAD,
  output logic [ADDR_W-1:0]  oADDRESS,
  output logic [DATA_W-1:0]  oWRITEDATA,
  input  logic               iWAITREQUEST,
  input  logic [DATA_W-1:0]  iREADDATA,
  input  logic               iREADDATAVALID,
  output logic               oBUSY,
  output logic               oPASS,
  output logic               oFAIL,
  output logic               oCOMPLETE,
  output logic               oTIMEOUT,
  output logic [ERR_W-1:0]   oERR_COUNT,
  output logic [DEPTH_W-1:0] oFIRST_ERR_ADDR,
  output logic [3:0]         oSTATE
);

  localparam int CNT_W = (TIMEOUT_W > 8) ? TIMEOUT_W : 8;

  state_t             state, state_nx;
  logic [1:0]         btn_sync;
  logic               btn_d, trig, start;
  logic [CNT_W-1:0]   cyc;
  logic [DEPTH_W-1:0] addr;
  logic [DATA_W-1:0]  rd_data, exp_word;
  mode_t              mode_q;
  logic               stop_q, timeout_q;
  logic [ERR_W-1:0]   err_cnt;
  logic [DEPTH_W-1:0] first_err;
  logic               last_addr, mismatch, gap_done, turn_done, to_done;
  logic               lfsr_load, lfsr_step;

  assign start     = trig && (state == ST_IDLE || state == ST_PASS || state == ST_FAIL);
  assign last_addr = &addr;
  assign mismatch  = (rd_data != exp_word);
  assign gap_done  = (cyc == CNT_W'(GAP_CYCLES - 1));
  assign turn_done = (cyc == CNT_W'(1));
  assign to_done   = (cyc == CNT_W'({TIMEOUT_W{1'b1}}));

  always_ff @(posedge iCLK) begin
    if (!iRST_n) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    lfsr_load = start;
    lfsr_step = 1'b0;
    if (start) state_nx = ST_WR_GAP;
    else begin
      case (state)
        ST_WR_GAP:  if (gap_done) state_nx = ST_WR_REQ;
        ST_WR_REQ:  if (!iWAITREQUEST) begin
                      state_nx  = ST_WR_NEXT;
                      lfsr_step = 1'b1;
                    end
        ST_WR_NEXT: state_nx = last_addr ? ST_TURN : ST_WR_GAP;
        ST_TURN:    begin
                      lfsr_load = 1'b1;
                      if (turn_done) state_nx = ST_RD_REQ;
                    end
        ST_RD_REQ:  if (!iWAITREQUEST) state_nx = ST_RD_WAIT;
        ST_RD_WAIT: if (iREADDATAVALID) state_nx = ST_CMP;
                    else if (to_done)   state_nx = ST_FAIL;
        ST_CMP:     begin
                      lfsr_step = 1'b1;
                      state_nx  = (mismatch && stop_q) ? ST_FAIL : ST_RD_NEXT;
                    end
        ST_RD_NEXT: if (!last_addr)        state_nx = ST_RD_REQ;
                    else if (err_cnt == '0) state_nx = ST_PASS;
                    else                    state_nx = ST_FAIL;
        default:    state_nx = state;
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_n) begin
      btn_sync  <= 2'b11;
      btn_d     <= 1'b1;
      trig      <= 1'b0;
      cyc       <= '0;
      addr      <= '0;
      rd_data   <= '0;
      mode_q    <= PAT_ADDR;
      stop_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_cnt   <= '0;
      first_err <= '0;
    end else begin
      btn_sync <= {btn_sync[0], iBUTTON};
      btn_d    <= btn_sync[1];
      trig     <= btn_d & ~btn_sync[1];
      // one shared cycle counter, restarted on every state change
      cyc      <= (state_nx != state) ? '0 : cyc + 1'b1;
      if (start) begin
        addr      <= '0;
        mode_q    <= mode_t'(iMODE);
        stop_q    <= iSTOP_ON_ERR;
        timeout_q <= 1'b0;
        err_cnt   <= '0;
        first_err <= '0;
      end else begin
        case (state)
          ST_WR_NEXT, ST_RD_NEXT: addr <= last_addr ? '0 : addr + 1'b1;
          ST_RD_WAIT: if (iREADDATAVALID) rd_data   <= iREADDATA;
                      else if (to_done)   timeout_q <= 1'b1;
          ST_CMP: if (mismatch) begin
                    if (err_cnt == '0) first_err <= addr;
                    if (err_cnt != '1) err_cnt   <= err_cnt + 1'b1;
                  end
          default: ;
        endcase
      end
    end
  end

  sdram_pattern_gen #(
    .DATA_W    (DATA_W),
    .DEPTH_W   (DEPTH_W),
    .LFSR_SEED (LFSR_SEED)
  ) u_gen (
    .iCLK      (iCLK),
    .iRST_n    (iRST_n),
    .mode      (mode_q),
    .address   (addr),
    .lfsr_load (lfsr_load),
    .lfsr_step (lfsr_step),
    .expected  (exp_word)
  );

  assign oWRITE          = (state == ST_WR_REQ);
  assign oREAD           = (state == ST_RD_REQ);
  assign oADDRESS        = ADDR_W'(addr);
  assign oWRITEDATA      = exp_word;
  assign oBUSY           = !(state == ST_IDLE || state == ST_PASS || state == ST_FAIL);
  assign oPASS           = (state == ST_PASS);
  assign oFAIL           = (state == ST_FAIL);
  assign oCOMPLETE       = oPASS | oFAIL;
  assign oTIMEOUT        = timeout_q;
  assign oERR_COUNT      = err_cnt;
  assign oFIRST_ERR_ADDR = first_err;
  assign oSTATE          = state;

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Bench for sdram_pattern_tester: 16-word memory model with random stall and
// read latency, checked against pattern rules computed directly from address.
module tb_sdram_pattern_tester;

  localparam int ADDR_W = 25, DATA_W = 16, DEPTH_W = 4, GAP = 3, TO_W = 8;

  logic               iCLK = 1'b0, iRST_n = 1'b0, iBUTTON = 1'b1, iSTOP_ON_ERR = 1'b0;
  logic [1:0]         iMODE = 2'd0;
  logic               oWRITE, oREAD, iWAITREQUEST = 1'b0, iREADDATAVALID = 1'b0;
  logic [ADDR_W-1:0]  oADDRESS;
  logic [DATA_W-1:0]  oWRITEDATA, iREADDATA = '0;
  logic               oBUSY, oPASS, oFAIL, oCOMPLETE, oTIMEOUT;
  logic [15:0]        oERR_COUNT;
  logic [DEPTH_W-1:0] oFIRST_ERR_ADDR;
  logic [3:0]         oSTATE;

  sdram_pattern_tester #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_W(DEPTH_W), .GAP_CYCLES(GAP),
    .TIMEOUT_W(TO_W), .ERR_W(16), .LFSR_SEED(16'hACE1)
  ) dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iBUTTON(iBUTTON), .iMODE(iMODE),
    .iSTOP_ON_ERR(iSTOP_ON_ERR), .oWRITE(oWRITE), .oREAD(oREAD),
    .oADDRESS(oADDRESS), .oWRITEDATA(oWRITEDATA), .iWAITREQUEST(iWAITREQUEST),
    .iREADDATA(iREADDATA), .iREADDATAVALID(iREADDATAVALID), .oBUSY(oBUSY),
    .oPASS(oPASS), .oFAIL(oFAIL), .oCOMPLETE(oCOMPLETE), .oTIMEOUT(oTIMEOUT),
    .oERR_COUNT(oERR_COUNT), .oFIRST_ERR_ADDR(oFIRST_ERR_ADDR), .oSTATE(oSTATE)
  );

  always #5 iCLK = ~iCLK;

  int passed = 0, total = 0;
  int cyc_n = 0;
  always @(posedge iCLK) cyc_n++;

  // memory model configuration and logs
  int          wait_pct = 0, lat_min = 1, lat_max = 1, corrupt_addr = -1, withhold_addr = -1;
  logic [15:0] mem [16];
  int          wr_addr_q[$], rd_addr_q[$], wr_cyc_q[$], rd_cyc_q[$];
  logic [15:0] wr_data_q[$];
  int          stall_viol = 0, hi_addr_viol = 0;
  bit          pending = 0, prev_stall = 0;
  int          lat_cnt = 0, rd_pend_addr = 0;
  logic [42:0] prev_req;
  logic [15:0] lfsr_at [16];

  always @(negedge iCLK) begin
    iREADDATAVALID = 1'b0;
    if (!iRST_n) pending = 0;
    else if (pending) begin
      if (lat_cnt <= 1) begin
        pending = 0;
        if (rd_pend_addr != withhold_addr) begin
          iREADDATAVALID = 1'b1;
          iREADDATA = mem[rd_pend_addr] ^ ((rd_pend_addr == corrupt_addr) ? 16'h0001 : 16'h0000);
        end
      end else lat_cnt--;
    end
    if (prev_stall && {oWRITE, oREAD, oADDRESS, oWRITEDATA} !== prev_req) stall_viol++;
    if ((oWRITE || oREAD) && oADDRESS[ADDR_W-1:DEPTH_W] != '0) hi_addr_viol++;
    iWAITREQUEST = ($urandom_range(99) < wait_pct);
    if (iRST_n && oWRITE && !iWAITREQUEST) begin
      mem[oADDRESS[3:0]] = oWRITEDATA;
      wr_addr_q.push_back(int'(oADDRESS[3:0]));
      wr_data_q.push_back(oWRITEDATA);
      wr_cyc_q.push_back(cyc_n + 1);
    end
    if (iRST_n && oREAD && !iWAITREQUEST) begin
      pending      = 1;
      rd_pend_addr = int'(oADDRESS[3:0]);
      lat_cnt      = $urandom_range(lat_max, lat_min);
      rd_addr_q.push_back(rd_pend_addr);
      rd_cyc_q.push_back(cyc_n + 1);
    end
    prev_stall = iRST_n && (oWRITE || oREAD) && iWAITREQUEST;
    prev_req   = {oWRITE, oREAD, oADDRESS, oWRITEDATA};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] model_word(input int mode, input int a);
    case (mode)
      0:       return 16'(a);
      1:       return ~16'(a);
      2:       return 16'(1) << (a % 16);
      default: return lfsr_at[a];
    endcase
  endfunction

  // Press the button; if the tester is idle/finished, WR_GAP must follow 4 edges later.
  task automatic press(input bit expect_start);
    @(negedge iCLK); iBUTTON = 1'b0;
    repeat (3) @(negedge iCLK);
    if (expect_start) chk("pre_trigger_state", {31'd0, oBUSY}, 32'd0);
    @(negedge iCLK);
    if (expect_start) chk("start_state", oSTATE, 4'd1);
    iBUTTON = 1'b1;
  endtask

  task automatic start_run(input int mode, input bit stop, input int wpct,
                           input int lmin, input int lmax, input int corr, input int hold);
    iMODE = 2'(mode); iSTOP_ON_ERR = stop; wait_pct = wpct;
    lat_min = lmin; lat_max = lmax; corrupt_addr = corr; withhold_addr = hold;
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    rd_addr_q.delete(); rd_cyc_q.delete();
    press(1'b1);
  endtask

  task automatic wait_done(input string tag, input int budget, output int at);
    int n = 0;
    while (!oCOMPLETE && n < budget) begin @(negedge iCLK); n++; end
    at = cyc_n;
    chk({tag, "_done"}, {31'd0, oCOMPLETE}, 32'd1);
  endtask

  task automatic wait_state(input string tag, input logic [3:0] code, input int budget);
    int n = 0;
    while (oSTATE !== code && n < budget) begin @(negedge iCLK); n++; end
    chk({tag, "_reach"}, oSTATE, code);
  endtask

  // write log must be exactly addresses 0..15 carrying the model pattern
  task automatic check_writes(input string tag, input int mode);
    int bad = 0;
    for (int k = 0; k < wr_addr_q.size(); k++)
      if (wr_addr_q[k] != k || wr_data_q[k] !== model_word(mode, k)) bad++;
    chk({tag, "_wr_count"}, wr_addr_q.size(), 32'd16);
    chk({tag, "_wr_seq_bad"}, bad, 32'd0);
  endtask

  task automatic check_reads(input string tag, input int n);
    int bad = 0;
    for (int k = 0; k < rd_addr_q.size(); k++) if (rd_addr_q[k] != k) bad++;
    chk({tag, "_rd_count"}, rd_addr_q.size(), n);
    chk({tag, "_rd_seq_bad"}, bad, 32'd0);
  endtask

  task automatic check_status(input string tag, input bit pass, input int errs,
                              input int first, input bit tmo);
    chk({tag, "_pass"}, {31'd0, oPASS}, {31'd0, pass});
    chk({tag, "_fail"}, {31'd0, oFAIL}, {31'd0, !pass});
    chk({tag, "_state"}, oSTATE, pass ? 4'd9 : 4'd10);
    chk({tag, "_err_count"}, oERR_COUNT, errs);
    chk({tag, "_first_err"}, oFIRST_ERR_ADDR, first);
    chk({tag, "_timeout"}, {31'd0, oTIMEOUT}, {31'd0, tmo});
    chk({tag, "_busy"}, {31'd0, oBUSY}, 32'd0);
  endtask

  initial begin
    int at;
    lfsr_at[0] = 16'hACE1;
    for (int k = 1; k < 16; k++) begin
      logic [15:0] s;
      s = lfsr_at[k-1];
      lfsr_at[k] = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    end
    for (int k = 0; k < 16; k++) mem[k] = 16'hDEAD;

    // reset state
    repeat (4) @(negedge iCLK);
    iRST_n = 1'b1;
    @(negedge iCLK);
    chk("rst_state", oSTATE, 4'd0);
    chk("rst_strobes", {30'd0, oWRITE, oREAD}, 32'd0);
    chk("rst_status", {27'd0, oBUSY, oPASS, oFAIL, oCOMPLETE, oTIMEOUT}, 32'd0);
    chk("rst_addr", oADDRESS, 32'd0);
    chk("rst_wdata", oWRITEDATA, 32'd0);
    chk("rst_err", oERR_COUNT, 32'd0);

    // T1: address pattern, ideal memory, latency 2
    start_run(0, 0, 0, 2, 2, -1, -1);
    wait_done("t1", 2000, at);
    check_status("t1", 1, 0, 0, 0);
    check_writes("t1", 0);
    check_reads("t1", 16);
    chk("t1_wr_interval", wr_cyc_q[1] - wr_cyc_q[0], GAP + 2);
    chk("t1_complete", {31'd0, oCOMPLETE}, 32'd1);

    // T2: LFSR, random stall and latency; restart from PASS
    start_run(3, 0, 30, 1, 5, -1, -1);
    wait_done("t2", 4000, at);
    check_status("t2", 1, 0, 0, 0);
    check_writes("t2", 3);
    check_reads("t2", 16);

    // T3: corrupted word at address 5, continue on error
    start_run(0, 0, 20, 1, 3, 5, -1);
    wait_done("t3", 4000, at);
    check_status("t3", 0, 1, 5, 0);
    check_reads("t3", 16);

    // T4: same corruption, stop on first error
    start_run(0, 1, 20, 1, 3, 5, -1);
    wait_done("t4", 4000, at);
    check_status("t4", 0, 1, 5, 0);
    check_reads("t4", 6);

    // T5: walking one from FAIL, with an ignored press mid-write
    start_run(2, 0, 30, 1, 5, -1, -1);
    repeat (20) @(negedge iCLK);
    chk("t5_busy_before_press", {31'd0, oBUSY}, 32'd1);
    press(1'b0);
    chk("t5_err_cleared", oERR_COUNT, 32'd0);
    wait_done("t5", 4000, at);
    check_status("t5", 1, 0, 0, 0);
    check_writes("t5", 2);
    check_reads("t5", 16);

    // T6: read valid withheld at address 3 -> timeout
    start_run(1, 0, 0, 1, 2, -1, 3);
    wait_done("t6", 4000, at);
    check_status("t6", 0, 0, 0, 1);
    check_reads("t6", 4);
    if (rd_cyc_q.size() == 4) chk("t6_timeout_cycles", at - rd_cyc_q[3], 32'd256);
    else chk("t6_rd3_seen", rd_cyc_q.size(), 32'd4);

    // T7: reset asserted while waiting for read data
    start_run(3, 0, 0, 5, 5, -1, -1);
    wait_state("t7", 4'd6, 2000);
    iRST_n = 1'b0;
    @(negedge iCLK);
    chk("t7_state", oSTATE, 4'd0);
    chk("t7_strobes", {30'd0, oWRITE, oREAD}, 32'd0);
    chk("t7_busy", {31'd0, oBUSY}, 32'd0);
    iRST_n = 1'b1;
    repeat (8) @(negedge iCLK);
    chk("t7_idle_stays", oSTATE, 4'd0);

    chk("stall_stable", stall_viol, 32'd0);
    chk("addr_high_zero", hi_addr_viol, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sdram_pattern_tester.md
# sdram_pattern_tester

Parametrised SDRAM write/read-back tester sitting between a board push-button and the SDRAM controller's Avalon-style master port. On a button press it writes a selectable data pattern over a configurable address window, reads it back, and compares every word. It handles controller back-pressure and variable read latency, counts errors, and reports pass/fail/complete to LEDs and debug logic.

## Interface
- ADDR_W, 25, controller address width
- DATA_W, 16, data word width
- DEPTH_W, 16, tested window is addresses 0 .. 2^DEPTH_W-1 (DEPTH_W ≤ ADDR_W)
- GAP_CYCLES, 8, idle cycles before each write request (1..255)
- TIMEOUT_W, 8, read-valid timeout is 2^TIMEOUT_W cycles
- ERR_W, 16, error counter width
- LFSR_SEED, 16'hACE1, nonzero seed for LFSR pattern (low DATA_W bits used)
- iCLK  in  1  clock
- iRST_n  in  1  synchronous, active-low reset
- iBUTTON  in  1  start button, active-low, asynchronous
- iMODE  in  2  pattern select, sampled at start
- iSTOP_ON_ERR  in  1  1: stop at first mismatch; sampled at start
- oWRITE, oREAD  out  1  request strobes
- oADDRESS  out  ADDR_W  request address, bits above DEPTH_W are 0
- oWRITEDATA  out  DATA_W  write data
- iWAITREQUEST  in  1  controller stall
- iREADDATA  in  DATA_W  read data
- iREADDATAVALID  in  1  read data qualifier
- oBUSY, oPASS, oFAIL, oCOMPLETE  out  1  status; oCOMPLETE = oPASS | oFAIL
- oTIMEOUT  out  1  sticky: fail caused by read timeout
- oERR_COUNT  out  ERR_W  mismatches, saturating at all-ones
- oFIRST_ERR_ADDR  out  DEPTH_W  address of first mismatch
- oSTATE  out  4  current state code

## Operation
- Button: 2-flop synchroniser; trigger = registered falling edge. Trigger is accepted only in IDLE, PASS and FAIL and is ignored otherwise. Acceptance clears the counters and flags, latches iMODE/iSTOP_ON_ERR, sets address to 0, and enters WR_GAP.
- States (code): IDLE 0, WR_GAP 1, WR_REQ 2, WR_NEXT 3, TURN 4, RD_REQ 5, RD_WAIT 6, CMP 7, RD_NEXT 8, PASS 9, FAIL 10.
- WR_GAP: count GAP_CYCLES, then WR_REQ.
- WR_REQ: oWRITE=1 with pattern data. Hold address/data/strobe while iWAITREQUEST=1. Accept when iWAITREQUEST=0, then WR_NEXT with oWRITE=0.
- WR_NEXT: at last address → address 0, TURN; else address+1, WR_GAP.
- TURN: 2 cycles, reload LFSR to seed → RD_REQ.
- RD_REQ: oREAD=1, held under waitrequest; on accept → RD_WAIT. At most one read outstanding.
- RD_WAIT: on iREADDATAVALID, register data → CMP. If 2^TIMEOUT_W cycles elapse without valid → set oTIMEOUT, FAIL.
- CMP: mismatch → err_count+1 (saturating); first mismatch captures the address. If mismatch and stop-on-error → FAIL; else RD_NEXT.
- RD_NEXT: at last address → PASS if err_count==0 else FAIL; else address+1, RD_REQ.
- Patterns:
  - 0: address zero-extended/truncated to DATA_W
  - 1: ~pattern 0
  - 2: walking one, 1<<(address mod DATA_W)
  - 3: Fibonacci LFSR (taps for x^16+x^14+x^13+x^11+1 over the low 16 bits; for DATA_W>16 the word is replicated), advanced once per accepted write and once per CMP.
- oBUSY = state not in {IDLE, PASS, FAIL}.
- PASS/FAIL are sticky until the next trigger or reset.

## Timing
- Reset: all outputs 0, state IDLE, address 0, LFSR = seed, synchroniser = 2'b11.
- Start: button low edge → trigger 3 cycles later → WR_GAP the cycle after.
- Per word with no stall: write = GAP_CYCLES+2 cycles; read = 3 + read latency cycles.
- Waitrequest stalls add exactly one cycle per stalled cycle. Outputs are stable throughout the stall.
- iREADDATAVALID outside RD_WAIT is ignored.
- Reset mid-test: synchronous return to IDLE next edge, no strobes asserted.
- Last address = all ones in address[DEPTH_W-1:0]. There is no wrap beyond the window.

## Structure
- Package sdram_test_pkg: state codes, mode codes (PAT_ADDR, PAT_NADDR, PAT_WALK1, PAT_LFSR), LFSR tap constant.
- Sub-module sdram_pattern_gen: inputs mode, address, lfsr_load, lfsr_step; output expected word. Used for both write data and compare data.

## Test plan
- DEPTH_W=4, mode 0, ideal memory, zero waitrequest, latency 2 → 16 writes of data 0..15, PASS, oERR_COUNT=0, oSTATE=9.
- Mode 3, random waitrequest (~30%), latency 1..5 → PASS. Write and read sequences equal the LFSR sequence from 16'hACE1.
- Memory corrupts address 5 (bit 0 flipped), continue mode → FAIL, oERR_COUNT=1, oFIRST_ERR_ADDR=5, all 16 reads issued.
- Same corruption, iSTOP_ON_ERR=1 → FAIL, the read of address 6 is never issued.
- Read valid withheld at address 3 → after 256 cycles FAIL, oTIMEOUT=1.
- Press during busy is ignored. Press in PASS restarts with cleared counters. Reset asserted in RD_WAIT → IDLE, strobes 0 next cycle.
